hazard_unit_pipe: RTL and testbench
===================================

Name: hazard_unit_pipe

Overview:
Pipeline hazard controller for the 5-stage (F/D/E/M/W) 24-bit processor. It takes decode-stage register addresses and control bits and tracks them internally through E/M/W shadow registers. From these it generates the stall/flush controls for every pipeline register and the operand-forwarding selects for the execute stage. It also supervises data-memory wait states with a timeout counter.

Parameters:
REG_W, 4, register address width (16 architectural registers)
PC_REG, 15, register index read as PC+8 by the register file; never matched for forwarding or hazards
WAIT_MAX, 15, maximum consecutive mem-wait cycles before timeout error
CNT_W, 4, width of the wait counter; must hold WAIT_MAX

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ra1_d, ra2_d, ra3_d  in  4 each  decode-stage source register addresses
wa_d  in  4  decode-stage destination register
reg_write_d  in  1  decode instruction writes the register file
mem_read_d  in  1  decode instruction is a load
branch_taken_e  in  1  branch resolved taken in execute
mem_ready_m  in  1  data memory done; 0 = wait state
stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding pipeline register
flush_d, flush_e, flush_w  out  1 each  load bubble into the corresponding pipeline register
fwd_a_e, fwd_b_e, fwd_c_e  out  2 each  execute operand select: 00 register file, 01 writeback result, 10 memory-stage ALU result
fwd_w_d  out  3  bit i = decode source i+1 must take the writeback result (same-cycle W->D bypass)
timeout_err  out  1  sticky memory-wait timeout flag

Behaviour:
- Shadow state: E = {ra1_e, ra2_e, ra3_e, wa_e, rw_e, mr_e}; M = {wa_m, rw_m, mr_m}; W = {wa_w, rw_w}.
- Reset (rst=0, async): all shadow bits 0, FSM = RUN, wait counter 0, timeout_err 0.
- During reset all outputs are 0 except flush_d, flush_e and flush_w, which are 1.
- Match rule: match(x, y) = (x == y) and (x != PC_REG).
- Load-use condition: lu = mr_e & rw_e & (match(wa_e, ra1_d) | match(wa_e, ra2_d) | match(wa_e, ra3_d)).
- FSM states: RUN, MEM_WAIT, ERR.
- RUN -> MEM_WAIT when mem_ready_m=0.
- MEM_WAIT -> RUN when mem_ready_m=1.
- MEM_WAIT -> ERR when the counter reaches WAIT_MAX with mem_ready_m still 0.
- ERR is left only by reset.
- Counter: increments each MEM_WAIT cycle; cleared on entry to RUN.
- Output priority (first match wins):
  1. ERR, or mem_ready_m=0: all four stall_* = 1, flush_w = 1. branch_taken_e and lu are ignored; shadow E/M hold, W loads a bubble.
  2. branch_taken_e=1: flush_d = flush_e = 1, no stalls. A simultaneous lu is discarded because the dependent instruction is flushed.
  3. lu=1: stall_f = stall_d = 1, flush_e = 1, giving exactly one bubble. On the next cycle mr_e = 0, so lu clears.
  4. Otherwise all stall_* and flush_* = 0.
- Shadow update (rising edge):
  - W <= M unless flush_w.
  - M <= E unless stall_m.
  - E <= decode inputs, or zeros when flush_e.
  - E holds when stall_e.
  - Zeros in E also result from a decode-stage bubble.
- Forwarding:
  - fwd_a_e = 10 if rw_m & match(wa_m, ra1_e) & ~mr_m.
  - else fwd_a_e = 01 if rw_w & match(wa_w, ra1_e).
  - else fwd_a_e = 00.
  - fwd_b_e and fwd_c_e follow the same rule using ra2_e and ra3_e.
  - M has priority over W when both match.
  - A load in M never forwards at 10 (its data is not yet available); load-use stalling guarantees correctness.
- fwd_w_d[i] = rw_w & match(wa_w, ra(i+1)_d).
- Forwarding outputs are combinational from shadow state and remain valid during stalls.
- Reset mid-wait: the FSM returns to RUN and the counter clears immediately.

Test Plan:
1. ALU dependence: ADD writes r3, next instruction reads r3 as ra1. In its E cycle fwd_a_e=10; with one intervening instruction fwd_a_e=01; no stall.
2. Load-use: LDR writes r5, next instruction reads r5 as ra2. Exactly one cycle of stall_f=stall_d=flush_e=1; the following cycle fwd_b_e=01.
3. PC exclusion: wa_d=15 with reg_write_d=1, next instruction reads r15. fwd_*=00 and no stall.
4. Branch + load-use: branch_taken_e=1 in the same cycle lu=1. flush_d=flush_e=1, stall_f=0.
5. Memory wait: mem_ready_m=0 for 3 cycles. All stalls=1 and flush_w=1 for 3 cycles, then RUN with the counter at 0. Holding it low for 16 cycles sets timeout_err=1 and keeps the stalls high until rst=0.
6. Async reset asserted mid-MEM_WAIT. All outputs clear immediately without a clock edge, with flush_d/e/w=1 while rst=0.

Source files
------------

// File: rtl/hazard_unit_pipe.sv
// hazard_unit_pipe: stall/flush/forwarding control for a 5-stage pipeline with a
// memory-wait supervisor that latches a timeout error.
module hazard_unit_pipe #(
  parameter int REG_W    = 4,
  parameter int PC_REG   = 15,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ra1_d,
  input  logic [REG_W-1:0] ra2_d,
  input  logic [REG_W-1:0] ra3_d,
  input  logic [REG_W-1:0] wa_d,
  input  logic             reg_write_d,
  input  logic             mem_read_d,
  input  logic             branch_taken_e,
  input  logic             mem_ready_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic [1:0]       fwd_c_e,
  output logic [2:0]       fwd_w_d,
  output logic             timeout_err
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [REG_W-1:0] ra1_e, ra2_e, ra3_e, wa_e, wa_m, wa_w;
  logic rw_e, mr_e, rw_m, mr_m, rw_w;
  logic hold, lu;

  function automatic logic match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y);
    return (x == y) && (x != REG_W'(PC_REG));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] ra, input logic [REG_W-1:0] wm,
                                         input logic rm, input logic lm,
                                         input logic [REG_W-1:0] ww, input logic rww);
    return (rm && !lm && match(wm, ra)) ? 2'b10 : (rww && match(ww, ra)) ? 2'b01 : 2'b00;
  endfunction

  assign hold = (state == ERR) || !mem_ready_m;
  assign lu   = mr_e && rw_e && (match(wa_e, ra1_d) || match(wa_e, ra2_d) || match(wa_e, ra3_d));

  // Outputs are gated by reset so the pipeline sees bubbles, not stalls, while held in reset
  assign stall_f = rst && (hold || (!branch_taken_e && lu));
  assign stall_d = stall_f;
  assign stall_e = rst && hold;
  assign stall_m = rst && hold;
  assign flush_d = !rst || (!hold && branch_taken_e);
  assign flush_e = !rst || (!hold && (branch_taken_e || lu));
  assign flush_w = !rst || hold;
  assign timeout_err = state == ERR;

  assign fwd_a_e = fwd_sel(ra1_e, wa_m, rw_m, mr_m, wa_w, rw_w);
  assign fwd_b_e = fwd_sel(ra2_e, wa_m, rw_m, mr_m, wa_w, rw_w);
  assign fwd_c_e = fwd_sel(ra3_e, wa_m, rw_m, mr_m, wa_w, rw_w);
  assign fwd_w_d = {rw_w && match(wa_w, ra3_d), rw_w && match(wa_w, ra2_d), rw_w && match(wa_w, ra1_d)};

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      RUN:      state_nx = mem_ready_m ? RUN : MEM_WAIT;
      MEM_WAIT: begin
        state_nx = mem_ready_m ? RUN : (cnt_inc == CNT_W'(WAIT_MAX)) ? ERR : MEM_WAIT;
        cnt_nx   = mem_ready_m ? '0 : cnt_inc;
      end
      default:  state_nx = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
      {ra1_e, ra2_e, ra3_e, wa_e, rw_e, mr_e} <= '0;
      {wa_m, rw_m, mr_m} <= '0;
      {wa_w, rw_w} <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      {wa_w, rw_w} <= flush_w ? '0 : {wa_m, rw_m};
      if (!stall_m) {wa_m, rw_m, mr_m} <= {wa_e, rw_e, mr_e};
      if (!stall_e)
        {ra1_e, ra2_e, ra3_e, wa_e, rw_e, mr_e} <= flush_e ? '0 :
          {ra1_d, ra2_d, ra3_d, wa_d, reg_write_d, mem_read_d};
    end
  end
endmodule

// File: tb/tb_hazard_unit_pipe.sv
// tb_hazard_unit_pipe: directed per-cycle vectors; expected outputs are queued by the
// driver and checked by an independent negedge monitor.
module tb_hazard_unit_pipe;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] ra1_d = 0, ra2_d = 0, ra3_d = 0, wa_d = 0;
  logic reg_write_d = 0, mem_read_d = 0, branch_taken_e = 0, mem_ready_m = 1;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, timeout_err;
  logic [1:0] fwd_a_e, fwd_b_e, fwd_c_e;
  logic [2:0] fwd_w_d;

  typedef struct {
    int id;
    logic [16:0] exp;
  } item_t;
  item_t q[$];
  int n_cmp = 0, n_bad = 0, n_id = 0;

  always #5 clk = ~clk;

  hazard_unit_pipe dut (
    .clk(clk), .rst(rst), .ra1_d(ra1_d), .ra2_d(ra2_d), .ra3_d(ra3_d), .wa_d(wa_d),
    .reg_write_d(reg_write_d), .mem_read_d(mem_read_d), .branch_taken_e(branch_taken_e),
    .mem_ready_m(mem_ready_m), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_c_e(fwd_c_e), .fwd_w_d(fwd_w_d),
    .timeout_err(timeout_err)
  );

  // Packing: stall f,d,e,m | flush d,e,w | fwd a,b,c | fwd_w_d | timeout_err
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      logic [16:0] got;
      it  = q.pop_front();
      got = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
             fwd_a_e, fwd_b_e, fwd_c_e, fwd_w_d, timeout_err};
      n_cmp++;
      if (got !== it.exp) begin
        n_bad++;
        $display("FAIL vec%0d: got st=%b fl=%b fa=%b fb=%b fc=%b fw=%b to=%b, need st=%b fl=%b fa=%b fb=%b fc=%b fw=%b to=%b",
                 it.id, got[16:13], got[12:10], got[9:8], got[7:6], got[5:4], got[3:1], got[0],
                 it.exp[16:13], it.exp[12:10], it.exp[9:8], it.exp[7:6], it.exp[5:4], it.exp[3:1], it.exp[0]);
      end
    end
  end

  task automatic v(input logic [3:0] r1, r2, r3, w, input logic rw, mr, br, rdy, rs,
                   input logic [3:0] st, input logic [2:0] fl, input logic [1:0] fa, fb, fc,
                   input logic [2:0] fw, input logic to);
    item_t it;
    @(posedge clk);
    #1;
    {ra1_d, ra2_d, ra3_d, wa_d} = {r1, r2, r3, w};
    {reg_write_d, mem_read_d, branch_taken_e, mem_ready_m, rst} = {rw, mr, br, rdy, rs};
    it.id  = n_id++;
    it.exp = {st, fl, fa, fb, fc, fw, to};
    q.push_back(it);
  endtask

  task automatic nop(input logic rdy, input logic [3:0] st, input logic [2:0] fl, input logic to);
    v(0, 0, 0, 0, 0, 0, 0, rdy, 1, st, fl, 0, 0, 0, 0, to);
  endtask

  initial begin
    #2 rst = 0;
    // reset: flushes high, stalls suppressed even with memory waiting
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b111, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b111, 0, 0, 0, 0, 0);
    // ALU dependence: M->E (10), W->E (01), W->D bypass
    v(1, 2, 4, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(3, 6, 7, 8, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(3, 8, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0);
    v(0, 3, 3, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0, 3'b110, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // load-use: one bubble, then W forward on operand b
    v(1, 2, 4, 5, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(0, 5, 0, 9, 1, 0, 0, 1, 1, 4'b1100, 3'b010, 0, 0, 0, 0, 0);
    v(0, 5, 0, 9, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    // PC register never matches: M, W, W->D and load-use
    v(1, 2, 3, 15, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(15, 15, 15, 15, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(15, 15, 15, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(15, 15, 15, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // branch wins over load-use
    v(0, 0, 0, 6, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(6, 0, 0, 10, 1, 0, 1, 1, 1, 4'b0000, 3'b110, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(6, 0, 0, 11, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3'b001, 0);
    // 3-cycle memory wait holds E/M; producer still forwards afterwards
    repeat (3) v(11, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 3'b001, 0, 0, 0, 0, 0);
    v(11, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0);
    // 16 wait cycles trip the timeout; ERR keeps stalling after ready returns
    repeat (16) nop(0, 4'b1111, 3'b001, 0);
    repeat (2) nop(1, 4'b1111, 3'b001, 1);
    v(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b111, 0, 0, 0, 0, 0);
    // async reset mid-wait, sampled before any further clock edge
    repeat (2) nop(0, 4'b1111, 3'b001, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b111, 0, 0, 0, 0, 0);
    nop(1, 0, 0, 0);
    // 15 wait cycles stay below the timeout
    repeat (15) nop(0, 4'b1111, 3'b001, 0);
    nop(1, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses left unchecked, need 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
